uart_rx_deserializer: RTL and testbench

- Receive-side front end of the UART core.
- Samples the asynchronous RX line using the 16x baud enable, assembles 7- or 8-bit frames with optional parity, and writes each received byte into the 256x8 receive FIFO.
- Drives the FIFO's active-low write strobe and data bus directly; the FIFO write clock is the same CLK.
- Reports sticky parity, framing and overflow errors to the register interface.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx_deserializer.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared definitions for the UART receive path: receiver FSM
//               state encoding and the 16x oversampling tick indices.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Oversample tick index used to sample the start bit (middle of the bit).
    localparam logic [3:0] SAMPLE_MID = 4'd7;
    // Last tick index of a 16x bit period; wrapping past it lands mid-bit
    // once the start bit has been centred.
    localparam logic [3:0] OVS_LAST   = 4'd15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        WRITE  = 3'd5
    } rx_state_t;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the asynchronous RX line. Both
//               stages reset to 1 so an idle (high) line is seen during and
//               after reset.
// Ports       : CLK     - system clock
//               RESET_N - asynchronous active-low reset
//               RX      - asynchronous serial input
//               rx_s    - RX synchronised to CLK
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic CLK,
    input  logic RESET_N,
    input  logic RX,
    output logic rx_s
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= RX;
            r_sync <= r_meta;
        end
    end

    assign rx_s = r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deserializer
// Description : UART receive front end. Oversamples RX with the 16x baud
//               enable, assembles 7/8-bit frames with optional parity and
//               writes each byte to the receive FIFO. Keeps sticky parity,
//               framing and overflow flags.
// Ports       : CLK, RESET_N          - clock, async active-low reset
//               BAUD_EN               - 16x baud enable pulse
//               RX                    - asynchronous serial input
//               BIT8, PARITY_EN,
//               ODD_N_EVEN            - frame format
//               FIFO_FULL             - receive FIFO full flag
//               ERR_CLR               - clears sticky error flags
//               FIFO_WRB, FIFO_DATA   - FIFO write strobe (active low), data
//               PARITY_ERR,
//               FRAMING_ERR, OVERFLOW - sticky error flags
//               RX_BUSY               - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       BAUD_EN,
    input  logic       RX,
    input  logic       BIT8,
    input  logic       PARITY_EN,
    input  logic       ODD_N_EVEN,
    input  logic       FIFO_FULL,
    input  logic       ERR_CLR,
    output logic       FIFO_WRB,
    output logic [7:0] FIFO_DATA,
    output logic       PARITY_ERR,
    output logic       FRAMING_ERR,
    output logic       OVERFLOW,
    output logic       RX_BUSY
);

    logic       w_rx_s;
    rx_state_t  r_state;
    logic [3:0] r_tick;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_par_acc;   // running XOR of the data bits
    logic       r_par_pend;  // parity error of the current frame
    logic       r_wrb;
    logic [7:0] r_data;
    logic       r_busy;
    logic       r_perr;
    logic       r_ferr;
    logic       r_ovf;

    logic       w_tick_last;
    logic [3:0] w_tick_next;
    logic [2:0] w_last_bit;
    logic [7:0] w_byte;
    logic       w_stop_sample;
    logic       w_set_perr;
    logic       w_set_ferr;
    logic       w_set_ovf;

    uart_rx_sync u_sync (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .RX      (RX),
        .rx_s    (w_rx_s)
    );

    // After centring on the start bit, every wrap of the tick counter is a
    // mid-bit sample point for data, parity and stop bits.
    assign w_tick_last = BAUD_EN && (r_tick == OVS_LAST);
    assign w_tick_next = (r_tick == OVS_LAST) ? 4'd0 : r_tick + 4'd1;
    assign w_last_bit  = BIT8 ? 3'd7 : 3'd6;

    // Bits are shifted in from the top, so a 7-bit frame ends up in [7:1].
    assign w_byte = BIT8 ? r_shift : {1'b0, r_shift[7:1]};

    // Flags are raised on the stop-bit sample edge, which is the same edge
    // that drops FIFO_WRB, so they become visible together with the write.
    assign w_stop_sample = (r_state == STOP) && w_tick_last;
    assign w_set_perr    = w_stop_sample && r_par_pend;
    assign w_set_ferr    = w_stop_sample && !w_rx_s;
    assign w_set_ovf     = w_stop_sample && FIFO_FULL;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_tick     <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_par_acc  <= 1'b0;
            r_par_pend <= 1'b0;
            r_wrb      <= 1'b1;
            r_data     <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            // The strobe is only ever low for the single WRITE cycle.
            r_wrb <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (BAUD_EN && !w_rx_s) begin
                        r_state <= START;
                        r_tick  <= 4'd0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (BAUD_EN) begin
                        if (r_tick == SAMPLE_MID) begin
                            if (w_rx_s) begin
                                // Line back high mid start bit: glitch.
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state    <= DATA;
                                r_tick     <= 4'd0;
                                r_bit_cnt  <= 3'd0;
                                r_par_acc  <= 1'b0;
                                r_par_pend <= 1'b0;
                            end
                        end else begin
                            r_tick <= r_tick + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (BAUD_EN) begin
                        r_tick <= w_tick_next;
                        if (r_tick == OVS_LAST) begin
                            r_shift   <= {w_rx_s, r_shift[7:1]};
                            r_par_acc <= r_par_acc ^ w_rx_s;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == w_last_bit) begin
                                r_state <= PARITY_EN ? PARITY : STOP;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (BAUD_EN) begin
                        r_tick <= w_tick_next;
                        if (r_tick == OVS_LAST) begin
                            r_par_pend <= r_par_acc ^ w_rx_s ^ ODD_N_EVEN;
                            r_state    <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (BAUD_EN) begin
                        r_tick <= w_tick_next;
                        if (r_tick == OVS_LAST) begin
                            // Do not wait for the end of the stop bit so a
                            // back-to-back start bit is not missed.
                            r_state <= WRITE;
                            if (!FIFO_FULL) begin
                                r_wrb  <= 1'b0;
                                r_data <= w_byte;
                            end
                        end
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle as ERR_CLR wins.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_perr <= (r_perr && !ERR_CLR) || w_set_perr;
            r_ferr <= (r_ferr && !ERR_CLR) || w_set_ferr;
            r_ovf  <= (r_ovf  && !ERR_CLR) || w_set_ovf;
        end
    end

    assign FIFO_WRB    = r_wrb;
    assign FIFO_DATA   = r_data;
    assign PARITY_ERR  = r_perr;
    assign FRAMING_ERR = r_ferr;
    assign OVERFLOW    = r_ovf;
    assign RX_BUSY     = r_busy;

endmodule : uart_rx_deserializer
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_deserializer
// Description : Self-checking bench for uart_rx_deserializer. A table of
//               frames with hand-computed results plus directed sequences
//               for glitch rejection and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       BAUD_EN;
    logic       RX;
    logic       BIT8;
    logic       PARITY_EN;
    logic       ODD_N_EVEN;
    logic       FIFO_FULL;
    logic       ERR_CLR;
    logic       FIFO_WRB;
    logic [7:0] FIFO_DATA;
    logic       PARITY_ERR;
    logic       FRAMING_ERR;
    logic       OVERFLOW;
    logic       RX_BUSY;

    uart_rx_deserializer dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .BAUD_EN     (BAUD_EN),
        .RX          (RX),
        .BIT8        (BIT8),
        .PARITY_EN   (PARITY_EN),
        .ODD_N_EVEN  (ODD_N_EVEN),
        .FIFO_FULL   (FIFO_FULL),
        .ERR_CLR     (ERR_CLR),
        .FIFO_WRB    (FIFO_WRB),
        .FIFO_DATA   (FIFO_DATA),
        .PARITY_ERR  (PARITY_ERR),
        .FRAMING_ERR (FRAMING_ERR),
        .OVERFLOW    (OVERFLOW),
        .RX_BUSY     (RX_BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- write monitor ----------------
    logic       en_at_edge = 1'b0;
    int         wr_count   = 0;
    int         low_run    = 0;
    int         max_run    = 0;
    int         lat_bad    = 0;
    logic [7:0] last_data  = 8'h00;
    logic [2:0] flags_at_wr = 3'b000;

    always @(posedge CLK) en_at_edge <= BAUD_EN;

    always @(negedge CLK) begin
        if (RESET_N && !FIFO_WRB) begin
            low_run++;
            if (low_run == 1) begin
                wr_count++;
                last_data   = FIFO_DATA;
                flags_at_wr = {PARITY_ERR, FRAMING_ERR, OVERFLOW};
                // The edge that dropped the strobe must be a BAUD_EN edge.
                if (!en_at_edge) lat_bad++;
            end
        end else begin
            if (low_run > max_run) max_run = low_run;
            low_run = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    int   div          = 0;
    logic clr_mode     = 1'b0;
    logic clr_saw_zero = 1'b0;

    // One CLK cycle; BAUD_EN is high every 4th cycle. In clr_mode ERR_CLR
    // is pulsed on every baud cycle until OVERFLOW is seen to drop and
    // then rise again, i.e. the overflow was set under a coincident clear.
    task automatic step();
        @(negedge CLK);
        BAUD_EN = (div == 3);
        div = (div + 1) % 4;
        if (clr_mode) begin
            if (!OVERFLOW) clr_saw_zero = 1'b1;
            else if (clr_saw_zero) clr_mode = 1'b0;
            ERR_CLR = clr_mode && BAUD_EN;
        end
    endtask

    task automatic baud_ticks(input int n);
        int k = 0;
        while (k < n) begin
            step();
            if (BAUD_EN) k++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen,
                              input logic odd, input logic pb, input logic stp,
                              input logic clr_stop);
        BIT8 = b8; PARITY_EN = pen; ODD_N_EVEN = odd;
        RX = 1'b0;
        baud_ticks(16);
        for (int i = 0; i < (b8 ? 8 : 7); i++) begin
            RX = d[i];
            baud_ticks(16);
        end
        if (pen) begin
            RX = pb;
            baud_ticks(16);
        end
        RX = stp;
        if (clr_stop) begin
            clr_mode = 1'b1;
            clr_saw_zero = 1'b0;
        end
        baud_ticks(16);
        clr_mode = 1'b0;
        ERR_CLR = 1'b0;
        RX = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] d;
        logic       b8, pen, odd, pb, stp, full, clr_before, clr_stop;
        int         gap;
        logic       wr;
        logic [7:0] exp_data;
        logic       perr, ferr, ovf;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        //           d      b8    pen   odd   pb    stp   full  clrb  clrs  gap wr    data   perr  ferr  ovf
        vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0,  1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0,  1'b0, 8'h11, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0,  1'b0, 8'h11, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{8'h2A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0,  1'b1, 8'h2A, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0,  1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

        RESET_N = 1'b0; BAUD_EN = 1'b0; RX = 1'b1; BIT8 = 1'b1; PARITY_EN = 1'b0;
        ODD_N_EVEN = 1'b0; FIFO_FULL = 1'b0; ERR_CLR = 1'b0;

        // Reset state
        repeat (4) step();
        check("reset wrb",   {31'd0, FIFO_WRB},    32'd1);
        check("reset data",  {24'd0, FIFO_DATA},   32'h00);
        check("reset flags", {29'd0, PARITY_ERR, FRAMING_ERR, OVERFLOW}, 32'd0);
        check("reset busy",  {31'd0, RX_BUSY},     32'd0);
        RESET_N = 1'b1;
        baud_ticks(8);

        for (int i = 0; i < NV; i++) begin
            int wr0;
            wr0 = wr_count;
            FIFO_FULL = vecs[i].full;
            if (vecs[i].clr_before) begin
                ERR_CLR = 1'b1;
                step();
                ERR_CLR = 1'b0;
                check($sformatf("v%0d clr flags", i),
                      {29'd0, PARITY_ERR, FRAMING_ERR, OVERFLOW}, 32'd0);
            end
            send_frame(vecs[i].d, vecs[i].b8, vecs[i].pen, vecs[i].odd,
                       vecs[i].pb, vecs[i].stp, vecs[i].clr_stop);
            if (vecs[i].gap > 0) baud_ticks(vecs[i].gap);
            check($sformatf("v%0d writes", i), wr_count - wr0, {31'd0, vecs[i].wr});
            check($sformatf("v%0d data", i), {24'd0, FIFO_DATA}, {24'd0, vecs[i].exp_data});
            check($sformatf("v%0d perr", i), {31'd0, PARITY_ERR},  {31'd0, vecs[i].perr});
            check($sformatf("v%0d ferr", i), {31'd0, FRAMING_ERR}, {31'd0, vecs[i].ferr});
            check($sformatf("v%0d ovf", i),  {31'd0, OVERFLOW},    {31'd0, vecs[i].ovf});
            check($sformatf("v%0d busy", i), {31'd0, RX_BUSY},     32'd0);
            if (vecs[i].wr) begin
                check($sformatf("v%0d written byte", i), {24'd0, last_data}, {24'd0, vecs[i].exp_data});
                check($sformatf("v%0d flags at write", i), {29'd0, flags_at_wr},
                      {29'd0, vecs[i].perr, vecs[i].ferr, vecs[i].ovf});
            end
        end
        FIFO_FULL = 1'b0;

        // Glitch on RX: short low pulse is rejected at the start-bit check.
        begin
            int wr0;
            wr0 = wr_count;
            BIT8 = 1'b1; PARITY_EN = 1'b0;
            RX = 1'b0;
            baud_ticks(4);
            check("glitch busy during", {31'd0, RX_BUSY}, 32'd1);
            RX = 1'b1;
            baud_ticks(24);
            check("glitch busy after", {31'd0, RX_BUSY}, 32'd0);
            check("glitch writes", wr_count - wr0, 32'd0);
            check("glitch flags", {29'd0, PARITY_ERR, FRAMING_ERR, OVERFLOW}, 32'b100);
            check("glitch data", {24'd0, FIFO_DATA}, 32'h80);
        end

        // Reset asserted in the middle of a data bit aborts the frame.
        begin
            int wr0;
            wr0 = wr_count;
            BIT8 = 1'b0; PARITY_EN = 1'b0;
            RX = 1'b0;
            baud_ticks(16);
            for (int b = 0; b < 3; b++) begin
                RX = b[0] ? 1'b0 : 1'b1;
                baud_ticks(16);
            end
            RX = 1'b0;
            baud_ticks(8);
            check("pre-reset busy", {31'd0, RX_BUSY}, 32'd1);
            RESET_N = 1'b0;
            step();
            check("mid reset wrb",   {31'd0, FIFO_WRB},  32'd1);
            check("mid reset data",  {24'd0, FIFO_DATA}, 32'h00);
            check("mid reset flags", {29'd0, PARITY_ERR, FRAMING_ERR, OVERFLOW}, 32'd0);
            check("mid reset busy",  {31'd0, RX_BUSY},   32'd0);
            repeat (3) step();
            RX = 1'b1;
            RESET_N = 1'b1;
            baud_ticks(64);
            check("post reset writes", wr_count - wr0, 32'd0);
            check("post reset busy", {31'd0, RX_BUSY}, 32'd0);
            check("post reset data", {24'd0, FIFO_DATA}, 32'h00);
        end

        repeat (4) step();
        check("write pulse width", max_run, 32'd1);
        check("write latency", lat_bad, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_deserializer
`default_nettype wire
